// File: rtl/prog_clk_divider.sv
// Programmable clock divider with glitch-free reprogramming.
//
// A free-running counter wraps at the active terminal count D, producing a
// one-cycle tick every D+1 cycles. divided_clk either toggles on each wrap
// (50% duty, Fin/(2*(D+1))) or mirrors tick (pulse mode, Fin/(D+1)).
// New D/mode values are staged in a pending register and only take effect on
// a wrap edge (or immediately while disabled), so the output never glitches
// and the counter can never overshoot a smaller new terminal count.
//
// Ports:
//   clk          clock, all state on rising edge
//   rst          asynchronous active-high reset
//   enable       1 = count, 0 = hold idle (counter and outputs forced to 0)
//   div_value    new terminal count, sampled when div_load=1
//   div_mode     new mode (0 toggle, 1 pulse), sampled when div_load=1
//   div_load     single-cycle reprogram request
//   divided_clk  registered divided clock
//   tick         registered strobe, one cycle per wrap
//   load_pending registered, a loaded value awaits application
//   load_ack     registered strobe, a loaded value has just become active
module prog_clk_divider #(
  parameter int unsigned WIDTH       = 24,
  parameter int unsigned DEFAULT_DIV = 9999999
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [WIDTH-1:0] div_value,
  input  logic             div_mode,
  input  logic             div_load,
  output logic             divided_clk,
  output logic             tick,
  output logic             load_pending,
  output logic             load_ack
);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] active_div_q, active_div_d;
  logic             active_mode_q, active_mode_d;
  logic [WIDTH-1:0] pend_div_q, pend_div_d;
  logic             pend_mode_q, pend_mode_d;
  logic             pend_q, pend_d;
  logic             dclk_q, dclk_d;
  logic             tick_q, tick_d;
  logic             ack_q, ack_d;

  logic wrap;
  logic apply_edge;
  logic apply_new;
  logic apply_pend;
  logic next_mode;

  always_comb begin
    cnt_d         = cnt_q;
    active_div_d  = active_div_q;
    active_mode_d = active_mode_q;
    pend_div_d    = pend_div_q;
    pend_mode_d   = pend_mode_q;
    pend_d        = pend_q;
    dclk_d        = dclk_q;
    tick_d        = 1'b0;

    wrap       = enable && (cnt_q == active_div_q);
    // Applying is safe on a wrap edge, or at any edge while idle (no wrap will come).
    apply_edge = wrap || !enable;
    // A load coinciding with an apply edge bypasses (and discards) any older pending value.
    apply_new  = div_load && apply_edge;
    apply_pend = pend_q && apply_edge && !div_load;
    ack_d      = apply_new || apply_pend;

    if (apply_new) begin
      active_div_d  = div_value;
      active_mode_d = div_mode;
      pend_d        = 1'b0;
    end else if (apply_pend) begin
      active_div_d  = pend_div_q;
      active_mode_d = pend_mode_q;
      pend_d        = 1'b0;
    end else if (div_load) begin
      pend_div_d  = div_value;
      pend_mode_d = div_mode;
      pend_d      = 1'b1;
    end

    next_mode = active_mode_d;

    if (!enable) begin
      cnt_d  = '0;
      dclk_d = 1'b0;
    end else if (wrap) begin
      cnt_d  = '0;
      tick_d = 1'b1;
      if (next_mode) begin
        dclk_d = 1'b1;
      end else if (active_mode_q) begin
        // Entering toggle mode: toggle starting from 0.
        dclk_d = 1'b1;
      end else begin
        dclk_d = ~dclk_q;
      end
    end else begin
      cnt_d = cnt_q + WIDTH'(1);
      if (active_mode_q) begin
        dclk_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q         <= '0;
      active_div_q  <= WIDTH'(DEFAULT_DIV);
      active_mode_q <= 1'b0;
      pend_div_q    <= '0;
      pend_mode_q   <= 1'b0;
      pend_q        <= 1'b0;
      dclk_q        <= 1'b0;
      tick_q        <= 1'b0;
      ack_q         <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      active_div_q  <= active_div_d;
      active_mode_q <= active_mode_d;
      pend_div_q    <= pend_div_d;
      pend_mode_q   <= pend_mode_d;
      pend_q        <= pend_d;
      dclk_q        <= dclk_d;
      tick_q        <= tick_d;
      ack_q         <= ack_d;
    end
  end

  assign divided_clk  = dclk_q;
  assign tick         = tick_q;
  assign load_pending = pend_q;
  assign load_ack     = ack_q;

endmodule

// File: doc/prog_clk_divider.md
PROG_CLK_DIVIDER -- requirements
Module: prog_clk_divider

Interface
REQ-001 The block SHALL have parameter WIDTH, default 24, giving the width of the divide-count registers.
REQ-002 The block SHALL have parameter DEFAULT_DIV, default 9999999, giving the terminal count loaded at reset.
REQ-003 clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 enable  input  1  1 = count; 0 = hold the divider idle.
REQ-006 div_value  input  WIDTH  new terminal count D, sampled only when div_load=1.
REQ-007 div_mode  input  1  new output mode, sampled only when div_load=1: 0 = toggle, 1 = pulse.
REQ-008 div_load  input  1  single-cycle request to reprogram D and mode.
REQ-009 divided_clk  output  1  registered divided clock.
REQ-010 tick  output  1  registered one-cycle strobe at every terminal count.
REQ-011 load_pending  output  1  registered; a loaded value is waiting to be applied.
REQ-012 load_ack  output  1  registered one-cycle strobe when a loaded value becomes active.

Function
REQ-013 The internal state SHALL be: counter[WIDTH], active_div[WIDTH], active_mode, pending_div[WIDTH], pending_mode and the pending flag.
REQ-014 While enable=1 and counter!=active_div, counter SHALL increment by 1 each cycle.
REQ-015 While enable=1 and counter==active_div (wrap edge), counter SHALL go to 0 and tick SHALL be 1 for the following cycle; tick period is therefore active_div+1 cycles.
REQ-016 In toggle mode, divided_clk SHALL invert on every wrap edge, giving Fout = Fin/(2*(active_div+1)) at 50% duty.
REQ-017 In pulse mode, divided_clk SHALL equal tick in every cycle, giving Fout = Fin/(active_div+1) with a one-cycle high time.
REQ-018 active_div=0 SHALL be legal: tick stays 1 continuously; toggle mode gives Fin/2; pulse mode holds divided_clk at 1.
REQ-019 On div_load=1, div_value and div_mode SHALL be captured into the pending registers and load_pending SHALL be set; a later div_load before application overwrites the pending values (last write wins).
REQ-020 Pending values SHALL transfer to active on the next wrap edge.
REQ-021 On that transfer edge, load_pending SHALL clear and load_ack SHALL be 1 for the following cycle.
REQ-022 If div_load=1 coincides with a wrap edge, the new div_value/div_mode SHALL be applied directly on that edge and load_ack SHALL pulse; any older pending values SHALL be discarded and load_pending SHALL clear.
REQ-023 While enable=0, pending values SHALL be applied on the next edge (load_ack pulses), because no wrap will occur.
REQ-024 While enable=0, counter SHALL be forced to 0, and divided_clk and tick SHALL be 0.
REQ-025 On re-enable, the first tick SHALL occur active_div+1 cycles after enable is first sampled high.
REQ-026 When a mode change is applied on a wrap edge, divided_clk SHALL follow the new mode from that edge: toggle from 0 if entering toggle mode, or equal tick if entering pulse mode.
REQ-027 Changing active_div SHALL never make counter exceed active_div: counter is reset to 0 at every application edge, so no wrap-around through 2^WIDTH occurs.
REQ-028 All outputs SHALL be driven from flops; there is no combinational input-to-output path.

Reset
REQ-029 rst=1 SHALL asynchronously set: counter=0, active_div=DEFAULT_DIV, active_mode=0, pending values=0, load_pending=0, divided_clk=0, tick=0, load_ack=0.
REQ-030 Reset asserted mid-period or with a load pending SHALL discard all state; after release, counting restarts from 0 with DEFAULT_DIV when enable=1.
REQ-031 Deassertion of rst SHALL be synchronised externally to clk; the block makes no internal assumption about release timing.

Verification
REQ-032 DEFAULT_DIV=3, toggle mode, enable=1 after reset -> tick every 4 cycles; divided_clk period of 8 cycles with 4 high and 4 low.
REQ-033 Load D=1, mode=1 at counter=0 while active_div=3 -> load_pending=1 for 3 cycles, then load_ack pulses together with the next tick; afterwards divided_clk pulses one cycle in every 2.
REQ-034 div_load with D=5 on the exact wrap edge, then a second div_load with D=2 one cycle later -> D=5 takes effect immediately; D=2 is applied at the next wrap, 6 cycles later.
REQ-035 D=0 in toggle mode -> divided_clk toggles every cycle and tick stays 1; D=0 in pulse mode -> divided_clk stays 1.
REQ-036 enable dropped at counter=2, then div_load with D=7 while disabled -> outputs go 0, load_ack pulses next cycle; on re-enable, the first tick occurs on the 8th cycle.
REQ-037 rst pulsed mid-period with a load pending -> all outputs are 0 immediately without waiting for a clk edge; load_pending=0; after release, behaviour matches REQ-032.
